bin_to_bcd6: RTL and testbench

Sequential double-dabble converter that turns a binary count into six packed BCD digits for the six-digit multiplexed seven-segment display driver.
- Sits directly upstream of the display driver; the driver indexes its segment table with each 4-bit digit.
- Accepts one value per valid/ready handshake and converts one bit per clock.
- Holds its result stable between conversions so the display never shows intermediate values.

---
 rtl/bcd_pkg.sv | 17 +
 rtl/bcd_add3.sv | 11 +
 rtl/bin_to_bcd6.sv | 95 +++++++++
 tb/tb_bin_to_bcd6.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared BCD definitions used by the binary-to-BCD converter and the display driver.
package bcd_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BCD_NINE = 4'd9;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  // Evaluated at elaboration to size the overflow limit 10^n - 1.
  function automatic longint unsigned pow10(input int n);
    longint unsigned r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: add 3 to a BCD digit that is 5 or more.
module bcd_add3
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  output logic [DIGIT_W-1:0] adjusted
);

  assign adjusted = (digit >= DIGIT_W'(5)) ? digit + DIGIT_W'(3) : digit;

endmodule

// File: rtl/bin_to_bcd6.sv
// Sequential double-dabble converter: one input bit per clock, result held
// stable between conversions and saturated to all nines on overflow.
module bin_to_bcd6
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 20,
  parameter int DIGITS = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [BIN_W-1:0]           in_bin,
  output logic [DIGIT_W*DIGITS-1:0]  bcd,
  output logic                       done,
  output logic                       ovf
);

  localparam int BCD_W = DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam longint unsigned LIMIT = pow10(DIGITS) - 1;

  state_t state, state_next;

  logic [BIN_W-1:0] shreg;
  logic [BCD_W-1:0] scratch;
  logic [BCD_W-1:0] adjusted;
  logic [CNT_W-1:0] cnt;
  logic             ovf_pending;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_add3 u_add3 (
      .digit    (scratch[g*DIGIT_W +: DIGIT_W]),
      .adjusted (adjusted[g*DIGIT_W +: DIGIT_W])
    );
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = SHIFT;
      end
      SHIFT: begin
        if (cnt == CNT_W'(1)) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // The top digit's carry falls off the shift; overflowing inputs are
  // replaced by all nines in DONE, so that loss never reaches bcd.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg       <= '0;
      scratch     <= '0;
      cnt         <= '0;
      ovf_pending <= 1'b0;
      bcd         <= '0;
      ovf         <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            shreg       <= in_bin;
            scratch     <= '0;
            cnt         <= CNT_W'(BIN_W);
            ovf_pending <= 64'(in_bin) > LIMIT;
          end
        end
        SHIFT: begin
          {scratch, shreg} <= {adjusted, shreg} << 1;
          cnt              <= cnt - CNT_W'(1);
        end
        DONE: begin
          bcd  <= ovf_pending ? {DIGITS{BCD_NINE}} : scratch;
          ovf  <= ovf_pending;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd6.sv
// Self-checking bench for bin_to_bcd6: directed vector table, handshake and
// reset corner cases, then random values against an arithmetic reference.
module tb_bin_to_bcd6;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [19:0] in_bin;
  logic [23:0] bcd;
  logic        done;
  logic        ovf;

  int n_compared   = 0;
  int n_mismatched = 0;

  bin_to_bcd6 #(.BIN_W(20), .DIGITS(6)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_bin   (in_bin),
    .bcd      (bcd),
    .done     (done),
    .ovf      (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [19:0] bin;
    logic [23:0] bcd;
    logic        ovf;
  } vec_t;

  // Decimal digits by repeated division; anything above 999999 saturates.
  function automatic logic [23:0] ref_bcd(input int unsigned v);
    logic [23:0] r;
    int unsigned x;
    r = 24'h999999;
    if (v <= 999999) begin
      x = v;
      for (int i = 0; i < 6; i++) begin
        r[i*4 +: 4] = 4'(x % 10);
        x = x / 10;
      end
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Waits for in_ready, presents v for one accept edge, then counts cycles to done.
  task automatic apply_stimulus(input logic [19:0] v, output int lat);
    int waitc;
    waitc = 0;
    @(negedge clk);
    while (!in_ready && waitc < 100) begin
      @(negedge clk);
      waitc++;
    end
    in_valid = 1'b1;
    in_bin   = v;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (!done && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic check_output(input string name, input logic [19:0] v, input int lat);
    check({name, "_latency"}, 32'(lat), 32'd21);
    check({name, "_bcd"}, 32'(bcd), 32'(ref_bcd(32'(v))));
    check({name, "_ovf"}, 32'(ovf), 32'(v > 20'd999999));
    @(posedge clk);
    #1;
    check({name, "_done_width"}, 32'(done), 32'd0);
    check({name, "_ready_after"}, 32'(in_ready), 32'd1);
  endtask

  vec_t vecs[12];

  initial begin
    int lat;
    int cyc;
    int held_ok;
    logic [19:0] r;

    vecs[0]  = '{20'd0,       24'h000000, 1'b0};
    vecs[1]  = '{20'd345678,  24'h345678, 1'b0};
    vecs[2]  = '{20'd999999,  24'h999999, 1'b0};
    vecs[3]  = '{20'd1000000, 24'h999999, 1'b1};
    vecs[4]  = '{20'hFFFFF,   24'h999999, 1'b1};
    vecs[5]  = '{20'd7,       24'h000007, 1'b0};
    vecs[6]  = '{20'd1,       24'h000001, 1'b0};
    vecs[7]  = '{20'd9,       24'h000009, 1'b0};
    vecs[8]  = '{20'd10,      24'h000010, 1'b0};
    vecs[9]  = '{20'd99999,   24'h099999, 1'b0};
    vecs[10] = '{20'd100000,  24'h100000, 1'b0};
    vecs[11] = '{20'd555555,  24'h555555, 1'b0};

    rst = 1'b0;
    in_valid = 1'b0;
    in_bin = '0;
    #1 rst = 1'b1;
    #12;
    check("reset_bcd", 32'(bcd), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_ovf", 32'(ovf), 32'd0);
    check("reset_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].bin, lat);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd21);
      check($sformatf("vec%0d_bcd", i), 32'(bcd), 32'(vecs[i].bcd));
      check($sformatf("vec%0d_ovf", i), 32'(ovf), 32'(vecs[i].ovf));
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_done_width", i), 32'(done), 32'd0);
    end

    // Held in_valid while busy: second value waits for in_ready.
    @(negedge clk);
    in_valid = 1'b1;
    in_bin   = 20'd123456;
    @(posedge clk);
    #1;
    in_bin = 20'd654321;
    check("busy_ready_low", 32'(in_ready), 32'd0);
    lat = 0;
    while (!done && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("busy_first_latency", 32'(lat), 32'd21);
    check("busy_first_bcd", 32'(bcd), 32'h123456);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("busy_second_ready_low", 32'(in_ready), 32'd0);
    cyc = 1;
    held_ok = 1;
    while (!done && cyc < 100) begin
      if (bcd !== 24'h123456) held_ok = 0;
      @(posedge clk);
      #1;
      cyc++;
    end
    check("busy_bcd_held", 32'(held_ok), 32'd1);
    check("busy_done_gap", 32'(cyc), 32'd22);
    check("busy_second_bcd", 32'(bcd), 32'h654321);

    // Reset in the middle of a conversion.
    @(negedge clk);
    in_valid = 1'b1;
    in_bin   = 20'd500000;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_bcd", 32'(bcd), 32'd0);
    check("midrst_ready", 32'(in_ready), 32'd1);
    held_ok = 1;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (done !== 1'b0) held_ok = 0;
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (done !== 1'b0) held_ok = 0;
    end
    check("midrst_no_done", 32'(held_ok), 32'd1);
    check("midrst_bcd_after", 32'(bcd), 32'd0);
    apply_stimulus(20'd42, lat);
    check_output("after_rst_42", 20'd42, lat);

    for (int k = 0; k < 300; k++) begin
      if (k % 8 == 0) r = 20'($urandom_range(1000000, 1048575));
      else            r = 20'($urandom_range(0, 999999));
      apply_stimulus(r, lat);
      check_output($sformatf("rand%0d_%0d", k, r), r, lat);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
